// File: rtl/wb_pulse_arb_if.sv
// Bus bundle between NM Wishbone-style requesters, the arbiter and one shared pulse slave.
// master: requester/slave side that drives the i_* signals; slave: the arbiter itself.
interface wb_pulse_arb_if #(
  parameter int unsigned NM    = 4,
  parameter int unsigned DSIZE = 8
) ();
  logic [NM-1:0]       i_m_stb;
  logic [NM-1:0]       i_m_we;
  logic [NM*DSIZE-1:0] i_m_dat;
  logic [NM-1:0]       o_m_ack;
  logic                o_m_err;
  logic [DSIZE-1:0]    o_m_dat;
  logic [NM-1:0]       o_gnt;
  logic                o_s_stb;
  logic                o_s_we;
  logic [DSIZE-1:0]    o_s_dat;
  logic                i_s_ack;
  logic [DSIZE-1:0]    i_s_dat;

  modport master (
    output i_m_stb, i_m_we, i_m_dat, i_s_ack, i_s_dat,
    input  o_m_ack, o_m_err, o_m_dat, o_gnt, o_s_stb, o_s_we, o_s_dat
  );

  modport slave (
    input  i_m_stb, i_m_we, i_m_dat, i_s_ack, i_s_dat,
    output o_m_ack, o_m_err, o_m_dat, o_gnt, o_s_stb, o_s_we, o_s_dat
  );
endinterface

// File: rtl/wb_pulse_arb.sv
// Round-robin arbiter granting one of NM requesters access to a shared pulse slave.
// Optional ack timeout enabled by defining WB_PULSE_ARB_TIMEOUT_EN.
module wb_pulse_arb #(
  parameter int unsigned NM    = 4,
  parameter int unsigned DSIZE = 8,
  parameter int unsigned TMO   = 16
) (
  input logic           i_clk,
  input logic           i_rst,
  wb_pulse_arb_if.slave bus
);
  localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [NM-1:0] gnt_q, gnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] cand, win_idx;
  logic          win_found;
  logic          busy, sel_stb, tmo_hit, done;

  assign busy    = (state_q == StBusy);
  assign sel_stb = bus.i_m_stb[idx_q];

  // Search order starts one past the last granted requester and wraps.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NM; i++) begin
      cand = IW'((32'(last_q) + i) % NM);
      if (!win_found && bus.i_m_stb[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef WB_PULSE_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TMO + 1);

  logic [CW-1:0] cnt_q;

  // Fires once TMO full BUSY cycles have passed without ack; a same-cycle ack wins.
  assign tmo_hit = busy && sel_stb && !bus.i_s_ack && (cnt_q == CW'(TMO));

  always_ff @(posedge i_clk) begin
    if (i_rst || !busy || done) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end
`else
  // TMO has no effect in this build.
  assign tmo_hit = 1'b0 && (TMO != 0);
`endif

  // Ack, abort (granted strobe dropped) or timeout all end the transaction.
  assign done = busy && (bus.i_s_ack || !sel_stb || tmo_hit);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StBusy;
          idx_d   = win_idx;
          gnt_d   = NM'(1) << win_idx;
        end
      end
      default: begin
        if (done) begin
          state_d = StIdle;
          gnt_d   = '0;
          last_d  = idx_q;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= IW'(NM - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign bus.o_gnt   = gnt_q;
  assign bus.o_s_stb = busy && sel_stb && !tmo_hit;
  assign bus.o_s_we  = busy && bus.i_m_we[idx_q];
  assign bus.o_s_dat = busy ? bus.i_m_dat[32'(idx_q) * DSIZE +: DSIZE] : '0;
  assign bus.o_m_ack = (busy && (bus.i_s_ack || tmo_hit)) ? gnt_q : '0;
  assign bus.o_m_err = tmo_hit;
  assign bus.o_m_dat = bus.i_s_dat;
endmodule

// File: tb/tb_wb_pulse_arb.sv
// Self-checking bench for wb_pulse_arb: directed table, corner sequences, random vs. model.
module tb_wb_pulse_arb;
  localparam int unsigned NM    = 4;
  localparam int unsigned DSIZE = 8;
  localparam int unsigned TMO   = 16;

  logic i_clk = 1'b0;
  logic i_rst;

  wb_pulse_arb_if #(.NM(NM), .DSIZE(DSIZE)) bus ();

  wb_pulse_arb #(.NM(NM), .DSIZE(DSIZE), .TMO(TMO)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  int tests = 0;
  int fails = 0;

  // Reference model: owner is the granted requester, -1 when nobody holds the slave.
  int owner = -1;
  int last  = NM - 1;
  int cnt   = 0;

  typedef struct {
    logic [NM-1:0]    stb;
    logic [NM-1:0]    we;
    logic             ack;
    logic [DSIZE-1:0] sdat;
    logic [NM-1:0]    gnt;
    logic             s_stb;
    logic             s_we;
    logic [DSIZE-1:0] s_dat;
    logic [NM-1:0]    m_ack;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DSIZE-1:0] req_dat(input int k);
    return bus.i_m_dat[k*DSIZE +: DSIZE];
  endfunction

  function automatic bit model_tmo();
    bit t = 1'b0;
`ifdef WB_PULSE_ARB_TIMEOUT_EN
    t = (owner >= 0) && (cnt == TMO) && bus.i_m_stb[owner] && !bus.i_s_ack;
`endif
    return t;
  endfunction

  task automatic model_check();
    bit            busy = (owner >= 0);
    bit            tmo  = model_tmo();
    logic [NM-1:0] exp_gnt;
    exp_gnt = busy ? (NM'(1) << owner) : '0;
    check("rnd_gnt", bus.o_gnt, exp_gnt);
    check("rnd_s_stb", bus.o_s_stb, busy && bus.i_m_stb[owner] && !tmo);
    check("rnd_m_ack", bus.o_m_ack, (busy && (bus.i_s_ack || tmo)) ? exp_gnt : '0);
    check("rnd_m_err", bus.o_m_err, tmo);
    check("rnd_m_dat", bus.o_m_dat, bus.i_s_dat);
    if (busy) begin
      check("rnd_s_we", bus.o_s_we, bus.i_m_we[owner]);
      check("rnd_s_dat", bus.o_s_dat, req_dat(owner));
    end
  endtask

  task automatic model_step();
    bit tmo = model_tmo();
    if (i_rst) begin
      owner = -1;
      last  = NM - 1;
      cnt   = 0;
    end else if (owner < 0) begin
      for (int k = 1; k <= NM; k++) begin
        int idx;
        idx = (last + k) % NM;
        if (bus.i_m_stb[idx]) begin
          owner = idx;
          cnt   = 0;
          break;
        end
      end
    end else if (bus.i_s_ack || !bus.i_m_stb[owner] || tmo) begin
      last  = owner;
      owner = -1;
    end else begin
      cnt++;
    end
  endtask

  // Called at negedge+1: advance through one rising edge and stop at the next negedge.
  task automatic tick();
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
  endtask

  task automatic drive(input logic [NM-1:0] stb, input logic [NM-1:0] we, input logic ack,
                       input logic [DSIZE-1:0] sdat);
    bus.i_m_stb = stb;
    bus.i_m_we  = we;
    bus.i_s_ack = ack;
    bus.i_s_dat = sdat;
  endtask

  initial begin
    logic [NM-1:0] flip;

    i_rst = 1'b1;
    drive('0, '0, 1'b0, '0);
    bus.i_m_dat = {8'd33, 8'd22, 8'd100, 8'd11};

    // Single write, read, round-robin wrap, ack while idle.
    tbl[0]  = '{4'b0010, 4'b0010, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 8'd0,   4'b0000};
    tbl[1]  = '{4'b0010, 4'b0010, 1'b0, 8'h00, 4'b0010, 1'b1, 1'b1, 8'd100, 4'b0000};
    tbl[2]  = '{4'b0010, 4'b0010, 1'b0, 8'h00, 4'b0010, 1'b1, 1'b1, 8'd100, 4'b0000};
    tbl[3]  = '{4'b0010, 4'b0010, 1'b1, 8'h5a, 4'b0010, 1'b1, 1'b1, 8'd100, 4'b0010};
    tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 8'd0,   4'b0000};
    tbl[5]  = '{4'b0100, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 8'd0,   4'b0000};
    tbl[6]  = '{4'b0100, 4'b0000, 1'b1, 8'hff, 4'b0100, 1'b1, 1'b0, 8'd22,  4'b0100};
    tbl[7]  = '{4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 8'd0,   4'b0000};
    tbl[8]  = '{4'b1001, 4'b1001, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 8'd0,   4'b0000};
    tbl[9]  = '{4'b1001, 4'b1001, 1'b1, 8'h01, 4'b1000, 1'b1, 1'b1, 8'd33,  4'b1000};
    tbl[10] = '{4'b1001, 4'b1001, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 8'd0,   4'b0000};
    tbl[11] = '{4'b1001, 4'b1001, 1'b1, 8'h02, 4'b0001, 1'b1, 1'b1, 8'd11,  4'b0001};
    tbl[12] = '{4'b0000, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 8'd0,   4'b0000};
    tbl[13] = '{4'b0000, 4'b0000, 1'b1, 8'h07, 4'b0000, 1'b0, 1'b0, 8'd0,   4'b0000};

    @(negedge i_clk);
    tick();
    tick();
    #1;
    check("rst_gnt", bus.o_gnt, 4'b0000);
    check("rst_s_stb", bus.o_s_stb, 1'b0);
    check("rst_m_ack", bus.o_m_ack, 4'b0000);
    check("rst_m_err", bus.o_m_err, 1'b0);
    tick();
    i_rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].stb, tbl[i].we, tbl[i].ack, tbl[i].sdat);
      #1;
      check($sformatf("tbl%0d_gnt", i), bus.o_gnt, tbl[i].gnt);
      check($sformatf("tbl%0d_s_stb", i), bus.o_s_stb, tbl[i].s_stb);
      check($sformatf("tbl%0d_m_ack", i), bus.o_m_ack, tbl[i].m_ack);
      check($sformatf("tbl%0d_m_err", i), bus.o_m_err, 1'b0);
      check($sformatf("tbl%0d_m_dat", i), bus.o_m_dat, tbl[i].sdat);
      if (tbl[i].gnt != '0) begin
        check($sformatf("tbl%0d_s_we", i), bus.o_s_we, tbl[i].s_we);
        check($sformatf("tbl%0d_s_dat", i), bus.o_s_dat, tbl[i].s_dat);
      end
      tick();
    end

    // Contention after reset with an always-acking slave: 0,1,2,3 with idle gaps.
    i_rst = 1'b1;
    drive('1, '0, 1'b1, 8'h00);
    tick();
    i_rst = 1'b0;
    for (int k = 0; k < NM; k++) begin
      #1;
      check($sformatf("cont%0d_idle_gnt", k), bus.o_gnt, 4'b0000);
      check($sformatf("cont%0d_idle_ack", k), bus.o_m_ack, 4'b0000);
      tick();
      #1;
      check($sformatf("cont%0d_gnt", k), bus.o_gnt, NM'(1) << k);
      check($sformatf("cont%0d_ack", k), bus.o_m_ack, NM'(1) << k);
      tick();
    end

    // Abort: granted requester drops its strobe before any ack.
    drive('0, '0, 1'b0, 8'h00);
    tick();
    drive(4'b0001, 4'b0001, 1'b0, 8'h00);
    #1;
    check("abort_idle_gnt", bus.o_gnt, 4'b0000);
    tick();
    #1;
    check("abort_busy_gnt", bus.o_gnt, 4'b0001);
    check("abort_busy_s_stb", bus.o_s_stb, 1'b1);
    tick();
    bus.i_m_stb = '0;
    #1;
    check("abort_ack", bus.o_m_ack, 4'b0000);
    check("abort_s_stb", bus.o_s_stb, 1'b0);
    tick();
    #1;
    check("abort_after_gnt", bus.o_gnt, 4'b0000);

    // Reset in the middle of a BUSY transaction.
    bus.i_m_stb = 4'b0010;
    tick();
    #1;
    check("rstbusy_gnt_before", bus.o_gnt, 4'b0010);
    i_rst = 1'b1;
    tick();
    #1;
    check("rstbusy_gnt", bus.o_gnt, 4'b0000);
    check("rstbusy_s_stb", bus.o_s_stb, 1'b0);
    check("rstbusy_m_ack", bus.o_m_ack, 4'b0000);
    i_rst = 1'b0;
    drive(4'b0100, 4'b0100, 1'b0, 8'h00);
    tick();

    // Slave never acks.
`ifdef WB_PULSE_ARB_TIMEOUT_EN
    for (int c = 1; c <= TMO; c++) begin
      #1;
      check($sformatf("tmo_wait%0d_ack", c), bus.o_m_ack, 4'b0000);
      check($sformatf("tmo_wait%0d_err", c), bus.o_m_err, 1'b0);
      tick();
    end
    #1;
    check("tmo_ack", bus.o_m_ack, 4'b0100);
    check("tmo_err", bus.o_m_err, 1'b1);
    check("tmo_s_stb", bus.o_s_stb, 1'b0);
    tick();
    #1;
    check("tmo_after_gnt", bus.o_gnt, 4'b0000);
    check("tmo_after_err", bus.o_m_err, 1'b0);
`else
    for (int c = 1; c <= 3 * TMO; c++) begin
      #1;
      check($sformatf("hold%0d_err", c), bus.o_m_err, 1'b0);
      check($sformatf("hold%0d_ack", c), bus.o_m_ack, 4'b0000);
      tick();
    end
    #1;
    check("hold_gnt", bus.o_gnt, 4'b0100);
    check("hold_s_stb", bus.o_s_stb, 1'b1);
`endif
    bus.i_m_stb = '0;
    tick();
    tick();

    // Random traffic against the reference model; strobes are sticky to exercise long holds.
    for (int n = 0; n < 3000; n++) begin
      flip = '0;
      for (int k = 0; k < NM; k++) flip[k] = ($urandom_range(5) == 0);
      bus.i_m_stb = bus.i_m_stb ^ flip;
      bus.i_m_we  = NM'($urandom);
      bus.i_m_dat = (NM*DSIZE)'($urandom);
      bus.i_s_ack = ($urandom_range(3) == 0);
      bus.i_s_dat = DSIZE'($urandom);
      i_rst       = ($urandom_range(63) == 0);
      #1;
      model_check();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
